// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encodings, default geometry and small geometry helpers.
package icache_pkg;

  localparam int DEFAULT_INDEX_BITS = 8;
  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int WORD_BITS          = 32;
  localparam int ADDR_BITS          = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_WAIT = 1'b1
  } icache_state_t;

  // Byte-offset width of a line: word select bits plus the two byte bits.
  function automatic int offset_bits(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int tag_bits(input int index_bits, input int line_words);
    return ADDR_BITS - index_bits - offset_bits(line_words);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: asynchronous read by
// index, single synchronous write port, valid bits cleared by reset.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int TAG_BITS   = tag_bits(DEFAULT_INDEX_BITS, DEFAULT_LINE_WORDS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [INDEX_BITS-1:0]           rd_index,
  output logic                            rd_valid,
  output logic [TAG_BITS-1:0]             rd_tag,
  output logic [WORD_BITS*LINE_WORDS-1:0] rd_line,
  input  logic                            wr_en,
  input  logic [INDEX_BITS-1:0]           wr_index,
  input  logic [TAG_BITS-1:0]             wr_tag,
  input  logic [WORD_BITS*LINE_WORDS-1:0] wr_line
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]                valid_bits;
  logic [TAG_BITS-1:0]             tag_mem  [LINES];
  logic [WORD_BITS*LINE_WORDS-1:0] data_mem [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= TRUE;
    end
  end

  // Tag and data are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: same-cycle hit to the fetcher, one-line
// refill from the memory controller on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rdy,
  input  logic                            fetch_enable,
  input  logic [ADDR_BITS-1:0]            fetch_pc,
  output logic                            icache_valid,
  output logic [WORD_BITS-1:0]            icache_inst,
  output logic                            mc_enable,
  output logic [ADDR_BITS-1:0]            mc_addr,
  input  logic                            mc_valid,
  input  logic [WORD_BITS*LINE_WORDS-1:0] mc_line,
  output icache_state_t                   state
);

  localparam int OFFSET_BITS = offset_bits(LINE_WORDS);
  localparam int TAG_BITS    = tag_bits(INDEX_BITS, LINE_WORDS);
  localparam int SEL_BITS    = OFFSET_BITS - 2;
  localparam int TAG_LSB     = INDEX_BITS + OFFSET_BITS;

  // Fetcher side: fetch_enable is a per-cycle request and icache_valid is the
  // same-cycle answer; there is no backpressure, a miss simply withholds
  // icache_valid. Memory side: mc_enable/mc_addr are held until the one-cycle
  // mc_valid pulse, which is accepted only in WAIT with rdy high.

  logic [TAG_BITS-1:0]             pc_tag;
  logic [INDEX_BITS-1:0]           pc_index;
  logic [SEL_BITS-1:0]             pc_word;
  logic                            unused_pc_bits;

  logic                            rd_valid;
  logic [TAG_BITS-1:0]             rd_tag;
  logic [WORD_BITS*LINE_WORDS-1:0] rd_line;
  logic [WORD_BITS-1:0]            line_words [LINE_WORDS];
  logic                            hit;

  logic                            wr_en;
  logic [INDEX_BITS-1:0]           wr_index;
  logic [TAG_BITS-1:0]             wr_tag;

  icache_state_t                   next_state;
  logic                            next_mc_enable;
  logic [ADDR_BITS-1:0]            next_mc_addr;

  assign pc_tag         = fetch_pc[ADDR_BITS-1:TAG_LSB];
  assign pc_index       = fetch_pc[TAG_LSB-1:OFFSET_BITS];
  assign pc_word        = fetch_pc[OFFSET_BITS-1:2];
  assign unused_pc_bits = ^fetch_pc[1:0];

  // The refill target comes from the latched request, not the live pc,
  // so a redirect during WAIT cannot corrupt the line being written.
  assign wr_index = mc_addr[TAG_LSB-1:OFFSET_BITS];
  assign wr_tag   = mc_addr[ADDR_BITS-1:TAG_LSB];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (pc_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_tag   (wr_tag),
    .wr_line  (mc_line)
  );

  always_comb begin
    for (int w = 0; w < LINE_WORDS; w++) begin
      line_words[w] = rd_line[w*WORD_BITS +: WORD_BITS];
    end
  end

  assign hit = rd_valid && (rd_tag == pc_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ICACHE_IDLE;
      mc_enable <= FALSE;
      mc_addr   <= '0;
    end else begin
      state     <= next_state;
      mc_enable <= next_mc_enable;
      mc_addr   <= next_mc_addr;
    end
  end

  always_comb begin
    next_state     = state;
    next_mc_enable = mc_enable;
    next_mc_addr   = mc_addr;
    wr_en          = FALSE;
    icache_valid   = FALSE;
    icache_inst    = '0;

    case (state)
      ICACHE_IDLE: begin
        if (rdy && fetch_enable) begin
          if (hit) begin
            icache_valid = TRUE;
            icache_inst  = line_words[pc_word];
          end else begin
            next_mc_addr   = {fetch_pc[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            next_mc_enable = TRUE;
            next_state     = ICACHE_WAIT;
          end
        end
      end
      ICACHE_WAIT: begin
        if (rdy && mc_valid) begin
          wr_en          = TRUE;
          next_mc_enable = FALSE;
          next_state     = ICACHE_IDLE;
        end
      end
      default: begin
        next_state     = ICACHE_IDLE;
        next_mc_enable = FALSE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// checked against a resident-line map and an arithmetic memory image.
module tb_icache;
  import icache_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rdy;
  logic          fetch_enable;
  logic [31:0]   fetch_pc;
  logic          icache_valid;
  logic [31:0]   icache_inst;
  logic          mc_enable;
  logic [31:0]   mc_addr;
  logic          mc_valid;
  logic [127:0]  mc_line;
  icache_state_t state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] resident [int];

  icache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rdy          (rdy),
    .fetch_enable (fetch_enable),
    .fetch_pc     (fetch_pc),
    .icache_valid (icache_valid),
    .icache_inst  (icache_inst),
    .mc_enable    (mc_enable),
    .mc_addr      (mc_addr),
    .mc_valid     (mc_valid),
    .mc_line      (mc_line),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Memory image: the word at byte address a is 0x13 + 0x80 * (a / 4).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h13 + ((a >> 2) << 7);
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] base);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = mem_word(base + 32'(4*w));
    return l;
  endfunction

  function automatic int index_of(input logic [31:0] a);
    return int'((a >> 4) & 32'hFF);
  endfunction

  function automatic logic model_hit(input logic [31:0] pc);
    int idx;
    idx = index_of(pc);
    return resident.exists(idx) && (resident[idx] == (pc & 32'hFFFF_FFF0));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a refill from cycle 1 of WAIT: mc_valid arrives in cycle lat.
  task automatic serve(input logic [31:0] base, input int lat);
    for (int c = 1; c < lat; c++) begin
      #2;
      total_cnt++;
      if (mc_enable !== 1'b1 || mc_addr !== base || icache_valid !== 1'b0)
        $display("FAIL serve_wait: mc_enable=%0b mc_addr=%h valid=%0b want 1/%h/0",
                 mc_enable, mc_addr, icache_valid, base);
      else pass_cnt++;
      tick();
    end
    mc_valid = 1'b1;
    mc_line  = line_of(base);
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0 || mc_enable !== 1'b1 || mc_addr !== base)
      $display("FAIL serve_pulse: valid=%0b mc_enable=%0b mc_addr=%h want 0/1/%h",
               icache_valid, mc_enable, mc_addr, base);
    else pass_cnt++;
    tick();
    mc_valid = 1'b0;
    mc_line  = '0;
    resident[index_of(base)] = base;
    total_cnt++;
    if (mc_enable !== 1'b0 || state !== ICACHE_IDLE)
      $display("FAIL serve_done: mc_enable=%0b state=%0d want 0/IDLE", mc_enable, state);
    else pass_cnt++;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int lat);
    logic [31:0] exp_w;
    fetch_enable = 1'b1;
    fetch_pc     = pc;
    if (!model_hit(pc)) begin
      #2;
      total_cnt++;
      if (icache_valid !== 1'b0 || icache_inst !== 32'h0)
        $display("FAIL fetch_miss: pc=%h valid=%0b inst=%h want 0/0", pc, icache_valid, icache_inst);
      else pass_cnt++;
      tick();
      serve(pc & 32'hFFFF_FFF0, lat);
    end
    exp_q.push_back(mem_word(pc & 32'hFFFF_FFFC));
    #2;
    exp_w = exp_q.pop_front();
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== exp_w)
      $display("FAIL fetch_hit: pc=%h valid=%0b inst=%h want 1/%h", pc, icache_valid, icache_inst, exp_w);
    else pass_cnt++;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; fetch_enable = 1'b1; fetch_pc = 32'h0;
    mc_valid = 1'b0; mc_line = '0;
    #3;
    total_cnt++;
    if (mc_enable !== 1'b0 || mc_addr !== 32'h0 || state !== ICACHE_IDLE)
      $display("FAIL reset_regs: mc_enable=%0b mc_addr=%h state=%0d want 0/0/IDLE", mc_enable, mc_addr, state);
    else pass_cnt++;
    total_cnt++;
    if (icache_valid !== 1'b0 || icache_inst !== 32'h0)
      $display("FAIL reset_outputs: valid=%0b inst=%h want 0/0", icache_valid, icache_inst);
    else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    fetch_enable = 1'b0;
    resident.delete();
    tick();
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0, 3);
    fetch_enable = 1'b1; fetch_pc = 32'hC;
    #2;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== 32'h193)
      $display("FAIL cold_hit_c: valid=%0b inst=%h want 1/00000193", icache_valid, icache_inst);
    else pass_cnt++;
    fetch_pc = 32'h4;
    #1;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== 32'h93)
      $display("FAIL cold_hit_4: valid=%0b inst=%h want 1/00000093", icache_valid, icache_inst);
    else pass_cnt++;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic test_conflict();
    do_fetch(32'h1000, 2);
    fetch_enable = 1'b1; fetch_pc = 32'h0;
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0)
      $display("FAIL conflict_evicted: valid=%0b want 0", icache_valid);
    else pass_cnt++;
    tick();
    serve(32'h0, 2);
    #2;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== 32'h13)
      $display("FAIL conflict_refill: valid=%0b inst=%h want 1/00000013", icache_valid, icache_inst);
    else pass_cnt++;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic test_redirect();
    fetch_enable = 1'b1; fetch_pc = 32'h40;
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0)
      $display("FAIL redirect_miss: valid=%0b want 0", icache_valid);
    else pass_cnt++;
    tick();
    fetch_pc = 32'h80;
    serve(32'h40, 4);
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0)
      $display("FAIL redirect_second_miss: valid=%0b want 0", icache_valid);
    else pass_cnt++;
    tick();
    serve(32'h80, 2);
    #2;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== mem_word(32'h80))
      $display("FAIL redirect_new_hit: valid=%0b inst=%h want 1/%h", icache_valid, icache_inst, mem_word(32'h80));
    else pass_cnt++;
    fetch_pc = 32'h44;
    #1;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== mem_word(32'h44))
      $display("FAIL redirect_old_hit: valid=%0b inst=%h want 1/%h", icache_valid, icache_inst, mem_word(32'h44));
    else pass_cnt++;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic test_stray_pulse();
    do_fetch(32'h208, 1);
    fetch_enable = 1'b0; fetch_pc = 32'h300;
    mc_valid = 1'b1; mc_line = line_of(32'h300);
    tick();
    mc_valid = 1'b0; mc_line = '0;
    total_cnt++;
    if (mc_enable !== 1'b0 || state !== ICACHE_IDLE)
      $display("FAIL stray_state: mc_enable=%0b state=%0d want 0/IDLE", mc_enable, state);
    else pass_cnt++;
    fetch_enable = 1'b1;
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0)
      $display("FAIL stray_no_fill: valid=%0b want 0", icache_valid);
    else pass_cnt++;
    tick();
    serve(32'h300, 1);
    fetch_enable = 1'b0;
    do_fetch(32'h20C, 1);
  endtask

  task automatic test_reset_mid_refill();
    fetch_enable = 1'b1; fetch_pc = 32'h500;
    tick();
    total_cnt++;
    if (mc_enable !== 1'b1 || mc_addr !== 32'h500)
      $display("FAIL rst_mid_req: mc_enable=%0b mc_addr=%h want 1/00000500", mc_enable, mc_addr);
    else pass_cnt++;
    #1;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (mc_enable !== 1'b0 || mc_addr !== 32'h0 || state !== ICACHE_IDLE)
      $display("FAIL rst_mid_async: mc_enable=%0b mc_addr=%h state=%0d want 0/0/IDLE", mc_enable, mc_addr, state);
    else pass_cnt++;
    resident.delete();
    fetch_enable = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_fetch(32'h0, 2);
  endtask

  task automatic test_rdy_low();
    fetch_enable = 1'b1; fetch_pc = 32'h0; rdy = 1'b0;
    #2;
    total_cnt++;
    if (icache_valid !== 1'b0)
      $display("FAIL rdy_low_idle_hit: valid=%0b want 0", icache_valid);
    else pass_cnt++;
    rdy = 1'b1; fetch_pc = 32'h600;
    tick();
    rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      total_cnt++;
      if (mc_enable !== 1'b1 || mc_addr !== 32'h600 || icache_valid !== 1'b0 || state !== ICACHE_WAIT)
        $display("FAIL rdy_low_hold: cyc=%0d mc_enable=%0b mc_addr=%h valid=%0b want 1/00000600/0",
                 c, mc_enable, mc_addr, icache_valid);
      else pass_cnt++;
      tick();
    end
    rdy = 1'b1;
    serve(32'h600, 2);
    #2;
    total_cnt++;
    if (icache_valid !== 1'b1 || icache_inst !== mem_word(32'h600))
      $display("FAIL rdy_low_done: valid=%0b inst=%h want 1/%h", icache_valid, icache_inst, mem_word(32'h600));
    else pass_cnt++;
    tick();
    fetch_enable = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        fetch_enable = 1'b0;
        fetch_pc     = $urandom;
        #2;
        total_cnt++;
        if (icache_valid !== 1'b0 || icache_inst !== 32'h0)
          $display("FAIL rand_idle: valid=%0b inst=%h want 0/0", icache_valid, icache_inst);
        else pass_cnt++;
        tick();
      end else begin
        pc = (32'($urandom_range(0, 2)) << 12) | (32'($urandom_range(0, 3)) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
        do_fetch(pc, $urandom_range(1, 4));
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_redirect();
    test_stray_pulse();
    test_reset_mid_refill();
    test_rdy_low();
    test_random();
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
